// File: rtl/wvb_readout_scheduler.sv
// Round-robin readout scheduler: one shared readout path for P_N_CHAN
// waveform channels. Pops a header, streams its samples, strobes read-done,
// then moves on to the next channel after the one just served.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   en, chan_mask       global enable / per-channel eligibility
//   hdr_empty, hdr_data per-channel show-ahead header FIFOs
//   wvb_data            per-channel sample data (1 cycle after wvb_rdreq)
//   hdr_rdreq           one-hot header pop
//   wvb_rdreq           one-hot sample read
//   wvb_rddone          one-hot waveform complete
//   dout_almost_full    downstream backpressure
//   dout_*              output beat (header on sop, samples otherwise)
//   busy, n_wvf_read    status
module wvb_readout_scheduler #(
  parameter int unsigned P_N_CHAN     = 4,
  parameter int unsigned P_CHAN_WIDTH = 2,
  parameter int unsigned P_DATA_WIDTH = 22,
  parameter int unsigned P_HDR_WIDTH  = 80,
  parameter int unsigned P_ADR_WIDTH  = 12,
  parameter int unsigned P_CNT_WIDTH  = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic [P_N_CHAN-1:0]               chan_mask,
  input  logic [P_N_CHAN-1:0]               hdr_empty,
  input  logic [P_N_CHAN*P_HDR_WIDTH-1:0]   hdr_data,
  input  logic [P_N_CHAN*P_DATA_WIDTH-1:0]  wvb_data,
  output logic [P_N_CHAN-1:0]               hdr_rdreq,
  output logic [P_N_CHAN-1:0]               wvb_rdreq,
  output logic [P_N_CHAN-1:0]               wvb_rddone,
  input  logic                              dout_almost_full,
  output logic                              dout_valid,
  output logic                              dout_sop,
  output logic                              dout_eop,
  output logic [P_CHAN_WIDTH-1:0]           dout_chan,
  output logic [P_HDR_WIDTH-1:0]            dout_hdr,
  output logic [P_DATA_WIDTH-1:0]           dout_data,
  output logic                              busy,
  output logic [P_CNT_WIDTH-1:0]            n_wvf_read
);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_DONE} state_t;

  state_t                   state, state_nxt;
  logic [P_CHAN_WIDTH-1:0]  chan, ptr, found_chan;
  logic                     found, hold, smp_beat;
  logic [P_ADR_WIDTH-1:0]   cnt;
  logic [P_N_CHAN-1:0]      pending, chan_onehot;
  logic [P_HDR_WIDTH-1:0]   hdr_arr [P_N_CHAN];
  logic [P_DATA_WIDTH-1:0]  wvb_arr [P_N_CHAN];

  for (genvar k = 0; k < P_N_CHAN; k++) begin : g_unpack
    assign hdr_arr[k] = hdr_data[k*P_HDR_WIDTH +: P_HDR_WIDTH];
    assign wvb_arr[k] = wvb_data[k*P_DATA_WIDTH +: P_DATA_WIDTH];
  end

  assign pending     = en ? (chan_mask & ~hdr_empty) : '0;
  assign chan_onehot = P_N_CHAN'(1) << chan;

  // First pending channel at or after ptr, wrapping.
  always_comb begin : sel_search
    int unsigned idx;
    idx        = 0;
    found      = 1'b0;
    found_chan = '0;
    for (int unsigned i = 0; i < P_N_CHAN; i++) begin
      idx = (32'(ptr) + i) % P_N_CHAN;
      if (!found && pending[P_CHAN_WIDTH'(idx)]) begin
        found      = 1'b1;
        found_chan = P_CHAN_WIDTH'(idx);
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state; a held selection proceeds only while it is still pending
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (!dout_almost_full && ((hold && pending[chan]) || (!hold && found)))
          state_nxt = S_HDR;
      end
      S_HDR:  state_nxt = S_DATA;
      S_DATA: if (!dout_almost_full && cnt == '0) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Strobe outputs
  always_comb begin
    hdr_rdreq  = '0;
    wvb_rdreq  = '0;
    wvb_rddone = '0;
    case (state)
      S_HDR:  hdr_rdreq  = chan_onehot;
      S_DATA: if (!dout_almost_full) wvb_rdreq = chan_onehot;
      S_DONE: wvb_rddone = chan_onehot;
      default: ;
    endcase
  end

  // Datapath: selection, length counter, output beat registers, status
  always_ff @(posedge clk) begin
    if (rst) begin
      chan       <= '0;
      ptr        <= '0;
      hold       <= 1'b0;
      cnt        <= '0;
      smp_beat   <= 1'b0;
      dout_valid <= 1'b0;
      dout_sop   <= 1'b0;
      dout_eop   <= 1'b0;
      dout_chan  <= '0;
      dout_hdr   <= '0;
      busy       <= 1'b0;
      n_wvf_read <= '0;
    end else begin
      dout_valid <= 1'b0;
      dout_sop   <= 1'b0;
      dout_eop   <= 1'b0;
      smp_beat   <= 1'b0;
      busy       <= (state_nxt != S_IDLE);
      case (state)
        S_IDLE: begin
          if (hold) begin
            if (!pending[chan] || !dout_almost_full) hold <= 1'b0;
          end else if (found) begin
            chan <= found_chan;
            hold <= dout_almost_full;
          end
        end
        S_HDR: begin
          dout_valid <= 1'b1;
          dout_sop   <= 1'b1;
          dout_chan  <= chan;
          dout_hdr   <= hdr_arr[chan];
          cnt        <= hdr_arr[chan][P_ADR_WIDTH-1:0];
        end
        S_DATA: begin
          if (!dout_almost_full) begin
            dout_valid <= 1'b1;
            smp_beat   <= 1'b1;
            dout_chan  <= chan;
            dout_eop   <= (cnt == '0);
            if (cnt != '0) cnt <= cnt - P_ADR_WIDTH'(1);
          end
        end
        S_DONE: begin
          n_wvf_read <= n_wvf_read + P_CNT_WIDTH'(1);
          if (chan == P_CHAN_WIDTH'(P_N_CHAN - 1)) ptr <= '0;
          else                                     ptr <= chan + P_CHAN_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  // Sample arrives from the buffer one cycle after its read strobe
  assign dout_data = smp_beat ? wvb_arr[dout_chan] : '0;

endmodule
